vga_timing_gen: RTL

Raster timing generator for the VGA text display path. It produces the pixel coordinate stream (`x`, `y`) consumed by the text renderer. It also produces sync and data-enable signals, delayed by a configurable number of cycles so they line up with the renderer's registered RGB output. Optionally it derives a once-per-second tick from the frame rate for the time-keeping logic.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counter with aligned decode,
// delayed sync/DE pins and an optional 1 Hz tick (macro VGA_TICK_1HZ_EN).
// Ports: clk, rst_n (async, active-low); x, y, active, line_start and
// frame_start aligned with the counter; hsync_o, vsync_o, de_o delayed
// by SYNC_DELAY cycles; tick_1hz (constant 0 unless VGA_TICK_1HZ_EN).
module vga_timing_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter bit HS_POL         = 1'b0,
    parameter bit VS_POL         = 1'b0,
    parameter int SYNC_DELAY     = 3,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de_o,
    output logic       tick_1hz
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
        end
        if (FRAMES_PER_SEC < 1 || SYNC_DELAY < 0) begin : g_bad_cfg
            $error("vga_timing_gen: bad FRAMES_PER_SEC or SYNC_DELAY");
        end
    endgenerate

    logic [9:0] x_n;
    logic [9:0] y_n;
    logic       act_n;
    logic       hs_n;
    logic       vs_n;
    logic       ls_n;
    logic       fs_n;
    logic       hs_a;
    logic       vs_a;

    // Decoding the next-state keeps every aligned output describing
    // the same pixel that x/y hold in the same cycle.
    always_comb begin
        x_n = x + 10'd1;
        y_n = y;
        if (x == H_LAST) begin
            x_n = '0;
            y_n = (y == V_LAST) ? '0 : y + 10'd1;
        end
        act_n = ({1'b0, x_n} < H_ACT) && ({1'b0, y_n} < V_ACT);
        hs_n  = ({1'b0, x_n} >= HS_BEG) && ({1'b0, x_n} < HS_END);
        vs_n  = ({1'b0, y_n} >= VS_BEG) && ({1'b0, y_n} < VS_END);
        ls_n  = (x_n == '0);
        fs_n  = (x_n == '0) && (y_n == '0);
    end

    // Reset parks the counter on the last pixel so the first edge
    // after release lands on (0,0) and the first frame is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= H_LAST;
            y           <= V_LAST;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs_a        <= ~HS_POL;
            vs_a        <= ~VS_POL;
        end else begin
            x           <= x_n;
            y           <= y_n;
            active      <= act_n;
            line_start  <= ls_n;
            frame_start <= fs_n;
            hs_a        <= hs_n ? HS_POL : ~HS_POL;
            vs_a        <= vs_n ? VS_POL : ~VS_POL;
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign hsync_o = hs_a;
            assign vsync_o = vs_a;
            assign de_o    = active;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hs_d;
            logic [SYNC_DELAY-1:0] vs_d;
            logic [SYNC_DELAY-1:0] de_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_d <= {SYNC_DELAY{~HS_POL}};
                    vs_d <= {SYNC_DELAY{~VS_POL}};
                    de_d <= '0;
                end else begin
                    hs_d[0] <= hs_a;
                    vs_d[0] <= vs_a;
                    de_d[0] <= active;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_d[i] <= hs_d[i-1];
                        vs_d[i] <= vs_d[i-1];
                        de_d[i] <= de_d[i-1];
                    end
                end
            end

            assign hsync_o = hs_d[SYNC_DELAY-1];
            assign vsync_o = vs_d[SYNC_DELAY-1];
            assign de_o    = de_d[SYNC_DELAY-1];
        end
    endgenerate

`ifdef VGA_TICK_1HZ_EN
    localparam int CW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [CW-1:0] F_LAST = CW'(FRAMES_PER_SEC - 1);

    logic [CW-1:0] fcnt;

    // Tick fires in the same cycle as the frame_start that wraps fcnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt     <= '0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= fs_n && (fcnt == F_LAST);
            if (fs_n) begin
                fcnt <= (fcnt == F_LAST) ? '0 : fcnt + CW'(1);
            end
        end
    end
`else
    assign tick_1hz = 1'b0;
`endif

endmodule
